// File: rtl/ss_rr_1h_to_b.sv
// ss_rr_1h_to_b: one-hot / multi-hot request vector to binary grant index.
//
// Picks one set bit of i_req and presents its binary index (o_idx) and the
// matching one-hot vector (o_onehot) one cycle after the request is accepted.
// The output sits in a single pipeline register with a valid/ready handshake
// on both sides. Backpressure reaches o_ready combinationally from i_ready.
//
// Selection modes (PRIO_MODE):
//   0 - round-robin: search upward from a rotating pointer, wrapping N-1 -> 0.
//       The pointer moves to (winner + 1) mod N on every productive accept.
//   1 - fixed priority: the lowest set bit wins. The pointer stays at zero.
//
// Optional feature:
//   SS_RR_MULTIHOT_ERR_EN - when defined, adds o_err. It is registered with
//   the selection and flags that the accepted request had more than one bit
//   set. Without the macro, multi-hot requests are arbitrated silently.

module ss_rr_1h_to_b #(
  parameter int INPUT_WIDTH  = 8,
  parameter int OUTPUT_WIDTH = $clog2(INPUT_WIDTH),
  parameter int PRIO_MODE    = 0
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [INPUT_WIDTH-1:0]  i_req,
  input  logic                    i_valid,
  output logic                    o_ready,
  output logic [OUTPUT_WIDTH-1:0] o_idx,
  output logic [INPUT_WIDTH-1:0]  o_onehot,
  output logic                    o_valid,
  input  logic                    i_ready
`ifdef SS_RR_MULTIHOT_ERR_EN
  ,
  output logic                    o_err
`endif
);

  localparam int N = INPUT_WIDTH;
  localparam int W = OUTPUT_WIDTH;

  // Highest legal index. The pointer wraps here, not at 2^W, so that
  // non-power-of-2 widths never leave the pointer on a nonexistent bit.
  localparam logic [W-1:0] LAST_IDX = W'(N - 1);
  localparam logic [N-1:0] ONE_HOT0 = N'(1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic         r_valid;
  logic [W-1:0] r_idx;
  logic [N-1:0] r_onehot;
  logic [W-1:0] r_ptr;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic w_accept;
  logic w_xfer;
  logic w_req_any;
  logic w_load;

  // The register can take a new value when it is empty or being drained.
  assign o_ready   = !r_valid || i_ready;
  assign w_accept  = i_valid && o_ready;
  assign w_xfer    = r_valid && i_ready;
  assign w_req_any = |i_req;

  // An all-zero request is still consumed, but produces nothing.
  assign w_load    = w_accept && w_req_any;

  // ---------------------------------------------------------------------------
  // Selection
  // ---------------------------------------------------------------------------
  // Search start point. Fixed-priority mode always searches from bit 0, which
  // turns the round-robin search below into a plain lowest-set-bit search.
  logic [W-1:0] w_ptr_eff;
  assign w_ptr_eff = (PRIO_MODE == 1) ? '0 : r_ptr;

  // Requests at or above the search start; if any exist, the lowest of them
  // wins, otherwise the search has wrapped and the lowest request overall wins.
  logic [N-1:0] w_upper_mask;
  logic [N-1:0] w_req_upper;

  // Build the "at or above pointer" mask one bit at a time.
  always_comb begin
    // NOTE: always_comb assigns every output a default before any branch or
    // loop, so no path leaves a value undriven and no latch is inferred.
    w_upper_mask = '0;
    for (int i = 0; i < N; i++) begin
      w_upper_mask[i] = (W'(i) >= w_ptr_eff);
    end
  end

  assign w_req_upper = i_req & w_upper_mask;

  logic         w_upper_found;
  logic [W-1:0] w_upper_idx;
  logic [W-1:0] w_wrap_idx;
  logic [W-1:0] w_sel;

  // Lowest-set-bit priority encoders for the masked and unmasked requests.
  always_comb begin
    // NOTE: combinational blocks use blocking '='; the loop walks downward so
    // the last assignment to win is the lowest set bit. Sequential state is
    // only ever written with non-blocking '<=' in always_ff.
    w_upper_found = 1'b0;
    w_upper_idx   = '0;
    w_wrap_idx    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_req_upper[i]) begin
        w_upper_found = 1'b1;
        w_upper_idx   = W'(i);
      end
      if (i_req[i]) begin
        w_wrap_idx = W'(i);
      end
    end
  end

  assign w_sel = w_upper_found ? w_upper_idx : w_wrap_idx;

  logic [N-1:0] w_sel_onehot;
  assign w_sel_onehot = ONE_HOT0 << w_sel;

  // Next pointer: one past the winner, wrapping at N.
  logic [W-1:0] w_ptr_next;
  assign w_ptr_next = (w_sel == LAST_IDX) ? '0 : (w_sel + W'(1));

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  // Load a fresh selection on a productive accept, otherwise empty the
  // register when its contents transfer downstream; hold while stalled.
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: every register here is reset, including the index and one-hot
    // payload, so the outputs read as zero while resetn is low.
    if (!resetn) begin
      r_valid  <= 1'b0;
      r_idx    <= '0;
      r_onehot <= '0;
    end else if (w_load) begin
      r_valid  <= 1'b1;
      r_idx    <= w_sel;
      r_onehot <= w_sel_onehot;
    end else if (w_xfer) begin
      r_valid  <= 1'b0;
    end
  end

  // Advance the round-robin pointer only when a selection is actually made.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ptr <= '0;
    end else if (w_load && (PRIO_MODE == 0)) begin
      r_ptr <= w_ptr_next;
    end
  end

  assign o_valid  = r_valid;
  assign o_idx    = r_idx;
  assign o_onehot = r_onehot;

`ifdef SS_RR_MULTIHOT_ERR_EN
  // ---------------------------------------------------------------------------
  // Multi-hot flag
  // ---------------------------------------------------------------------------
  // Clearing the lowest set bit leaves something behind only when two or
  // more bits were set.
  logic w_multi_hot;
  logic r_err;

  assign w_multi_hot = |(i_req & (i_req - ONE_HOT0));

  // Capture the flag alongside the selection so it travels with o_valid.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_err <= 1'b0;
    end else if (w_load) begin
      r_err <= w_multi_hot;
    end
  end

  assign o_err = r_err;
`endif

endmodule

// File: tb/tb_ss_rr_1h_to_b.sv
// Self-checking bench for ss_rr_1h_to_b.
// Three instances: N=8 round-robin, N=5 round-robin, N=16 fixed priority.
// The reference model is a one-entry output queue per instance plus a
// search pointer, computed directly from the selection rules.
// Honours SS_RR_MULTIHOT_ERR_EN when defined.

`timescale 1ns/1ps

module tb_ss_rr_1h_to_b;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn;

  // Instance 0: N=8, round-robin
  logic [7:0]  req0, oh0;
  logic [2:0]  idx0;
  logic        v0, rdy0, ordy0, ov0;
  // Instance 1: N=5, round-robin
  logic [4:0]  req1, oh1;
  logic [2:0]  idx1;
  logic        v1, rdy1, ordy1, ov1;
  // Instance 2: N=16, fixed priority
  logic [15:0] req2, oh2;
  logic [3:0]  idx2;
  logic        v2, rdy2, ordy2, ov2;
`ifdef SS_RR_MULTIHOT_ERR_EN
  logic        err0, err1, err2;
`endif

  ss_rr_1h_to_b #(.INPUT_WIDTH(8), .PRIO_MODE(0)) u_rr8 (
    .clk(clk), .resetn(resetn), .i_req(req0), .i_valid(v0), .o_ready(ordy0),
    .o_idx(idx0), .o_onehot(oh0), .o_valid(ov0), .i_ready(rdy0)
`ifdef SS_RR_MULTIHOT_ERR_EN
    , .o_err(err0)
`endif
  );

  ss_rr_1h_to_b #(.INPUT_WIDTH(5), .PRIO_MODE(0)) u_rr5 (
    .clk(clk), .resetn(resetn), .i_req(req1), .i_valid(v1), .o_ready(ordy1),
    .o_idx(idx1), .o_onehot(oh1), .o_valid(ov1), .i_ready(rdy1)
`ifdef SS_RR_MULTIHOT_ERR_EN
    , .o_err(err1)
`endif
  );

  ss_rr_1h_to_b #(.INPUT_WIDTH(16), .PRIO_MODE(1)) u_fp16 (
    .clk(clk), .resetn(resetn), .i_req(req2), .i_valid(v2), .o_ready(ordy2),
    .o_idx(idx2), .o_onehot(oh2), .o_valid(ov2), .i_ready(rdy2)
`ifdef SS_RR_MULTIHOT_ERR_EN
    , .o_err(err2)
`endif
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int  n_of    [3] = '{8, 5, 16};
  bit  prio_of [3] = '{1'b0, 1'b0, 1'b1};
  int  m_ptr   [3];
  bit  m_has   [3];
  int  m_idx   [3];
  bit  m_err   [3];

  int    checks = 0;
  int    errors = 0;
  string cur = "";

  // First requested index found walking upward from the pointer, modulo N.
  function automatic int model_pick(input int d, input logic [63:0] req);
    int start;
    int j;
    start = prio_of[d] ? 0 : m_ptr[d];
    for (int k = 0; k < n_of[d]; k++) begin
      j = (start + k) % n_of[d];
      if (req[j]) return j;
    end
    return -1;
  endfunction

  // Advance one instance's model across a rising edge.
  function automatic void model_clock(input int d, input bit v,
                                      input logic [63:0] req, input bit rdy);
    bit acc;
    bit xf;
    int sel;
    acc = v && (!m_has[d] || rdy);
    xf  = m_has[d] && rdy;
    if (xf) m_has[d] = 1'b0;
    if (acc && (req != 64'd0)) begin
      sel      = model_pick(d, req);
      m_has[d] = 1'b1;
      m_idx[d] = sel;
      m_err[d] = ($countones(req) > 1);
      if (!prio_of[d]) m_ptr[d] = (sel + 1) % n_of[d];
    end
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 3; d++) begin
      m_ptr[d] = 0;
      m_has[d] = 1'b0;
      m_idx[d] = 0;
      m_err[d] = 1'b0;
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Drive / sample helpers
  // ---------------------------------------------------------------------------
  // Drive instance d with the given stimulus; the others idle and drain.
  task automatic drive(input int d, input bit v, input logic [63:0] req, input bit rdy);
    req0 = (d == 0) ? req[7:0]  : 8'd0;
    v0   = (d == 0) && v;
    rdy0 = (d == 0) ? rdy : 1'b1;
    req1 = (d == 1) ? req[4:0]  : 5'd0;
    v1   = (d == 1) && v;
    rdy1 = (d == 1) ? rdy : 1'b1;
    req2 = (d == 2) ? req[15:0] : 16'd0;
    v2   = (d == 2) && v;
    rdy2 = (d == 2) ? rdy : 1'b1;
  endtask

  task automatic sample(input int d, output logic r, output logic v,
                        output logic [63:0] idx, output logic [63:0] oh,
                        output logic e);
    e = 1'b0;
    case (d)
      0: begin
        r = ordy0; v = ov0; idx = 64'(idx0); oh = 64'(oh0);
`ifdef SS_RR_MULTIHOT_ERR_EN
        e = err0;
`endif
      end
      1: begin
        r = ordy1; v = ov1; idx = 64'(idx1); oh = 64'(oh1);
`ifdef SS_RR_MULTIHOT_ERR_EN
        e = err1;
`endif
      end
      default: begin
        r = ordy2; v = ov2; idx = 64'(idx2); oh = 64'(oh2);
`ifdef SS_RR_MULTIHOT_ERR_EN
        e = err2;
`endif
      end
    endcase
  endtask

  // One clock of stimulus on instance d. Checks o_ready before the edge and
  // the registered outputs 1 ns after it. want_idx >= 0 adds a directed check.
  task automatic step(input int d, input bit v, input logic [63:0] req,
                      input bit rdy, input int want_idx);
    logic o_r, o_v, o_e;
    logic [63:0] o_i, o_oh;
    drive(d, v, req, rdy);
    #1;
    sample(d, o_r, o_v, o_i, o_oh, o_e);
    checks++;
    if (o_r !== (!m_has[d] || rdy)) begin
      errors++;
      $display("FAIL %s o_ready inst%0d: got %b want %b", cur, d, o_r, (!m_has[d] || rdy));
    end
    @(posedge clk);
    for (int dd = 0; dd < 3; dd++) begin
      if (dd == d) model_clock(dd, v, req, rdy);
      else         model_clock(dd, 1'b0, 64'd0, 1'b1);
    end
    #1;
    sample(d, o_r, o_v, o_i, o_oh, o_e);
    checks++;
    if (o_v !== m_has[d]) begin
      errors++;
      $display("FAIL %s o_valid inst%0d: got %b want %b", cur, d, o_v, m_has[d]);
    end
    if (m_has[d]) begin
      checks++;
      if (o_i !== 64'(m_idx[d])) begin
        errors++;
        $display("FAIL %s o_idx inst%0d: got %0d want %0d", cur, d, o_i, m_idx[d]);
      end
      checks++;
      if (o_oh !== (64'd1 << m_idx[d])) begin
        errors++;
        $display("FAIL %s o_onehot inst%0d: got %h want %h", cur, d, o_oh, 64'd1 << m_idx[d]);
      end
`ifdef SS_RR_MULTIHOT_ERR_EN
      checks++;
      if (o_e !== m_err[d]) begin
        errors++;
        $display("FAIL %s o_err inst%0d: got %b want %b", cur, d, o_e, m_err[d]);
      end
`endif
    end
    if (want_idx >= 0) begin
      checks++;
      if ((o_v !== 1'b1) || (o_i !== 64'(want_idx))) begin
        errors++;
        $display("FAIL %s directed inst%0d: got valid=%b idx=%0d want valid=1 idx=%0d",
                 cur, d, o_v, o_i, want_idx);
      end
    end
    @(negedge clk);
  endtask

  // Outputs of every instance must read as the reset state.
  task automatic check_reset_state();
    logic o_r, o_v, o_e;
    logic [63:0] o_i, o_oh;
    for (int d = 0; d < 3; d++) begin
      sample(d, o_r, o_v, o_i, o_oh, o_e);
      checks++;
      if ((o_v !== 1'b0) || (o_i !== 64'd0) || (o_oh !== 64'd0) ||
          (o_r !== 1'b1) || (o_e !== 1'b0)) begin
        errors++;
        $display("FAIL %s reset inst%0d: got valid=%b idx=%0d onehot=%h ready=%b err=%b want 0,0,0,1,0",
                 cur, d, o_v, o_i, o_oh, o_r, o_e);
      end
    end
  endtask

  function automatic logic [63:0] rand_req(input int n);
    logic [63:0] mask;
    logic [63:0] r;
    mask = (64'd1 << n) - 64'd1;
    case ($urandom_range(0, 7))
      0:       r = 64'd0;
      1, 2:    r = 64'd1 << $urandom_range(0, n - 1);
      default: r = {$urandom, $urandom} & mask;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    cur = "reset";
    resetn = 1'b0;
    drive(0, 1'b0, 64'd0, 1'b1);
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_state();
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_rr_sweep();
    cur = "rr_sweep";
    for (int k = 0; k < 4; k++) step(0, 1'b1, 64'hFF, 1'b1, k);
    step(0, 1'b0, 64'd0, 1'b1, -1);
  endtask

  task automatic test_wrap5();
    cur = "wrap5";
    step(1, 1'b1, 64'b10000, 1'b1, 4);
    step(1, 1'b1, 64'b00011, 1'b1, 0);
    step(1, 1'b1, 64'b11111, 1'b1, 1);
    step(1, 1'b0, 64'd0, 1'b1, -1);
  endtask

  task automatic test_stall();
    cur = "stall";
    step(0, 1'b0, 64'd0, 1'b1, -1);
    step(0, 1'b1, 64'h04, 1'b0, 2);
    for (int k = 0; k < 3; k++) step(0, 1'b1, 64'hFF, 1'b0, 2);
    step(0, 1'b0, 64'd0, 1'b1, -1);
  endtask

  task automatic test_prio16();
    cur = "prio16";
    step(2, 1'b1, 64'h8080, 1'b1, 7);
    step(2, 1'b1, 64'h8080, 1'b1, 7);
    step(2, 1'b1, 64'h8000, 1'b1, 15);
    step(2, 1'b0, 64'd0, 1'b1, -1);
  endtask

  task automatic test_zero_req();
    cur = "zero_req";
    step(0, 1'b1, 64'h10, 1'b1, 4);
    step(0, 1'b1, 64'h00, 1'b1, -1);
    step(0, 1'b1, 64'hFF, 1'b1, 5);
    step(0, 1'b0, 64'd0, 1'b1, -1);
  endtask

  task automatic test_multihot();
    cur = "multihot";
    step(0, 1'b1, 64'h06, 1'b1, -1);
    step(0, 1'b1, 64'h04, 1'b1, 2);
    step(0, 1'b0, 64'd0, 1'b1, -1);
  endtask

  task automatic test_back_to_back();
    int d;
    cur = "back_to_back";
    for (int k = 0; k < 600; k++) begin
      d = $urandom_range(0, 2);
      step(d, ($urandom_range(0, 3) != 0), rand_req(n_of[d]),
           ($urandom_range(0, 3) != 0), -1);
    end
    for (int dd = 0; dd < 3; dd++) step(dd, 1'b0, 64'd0, 1'b1, -1);
  endtask

  task automatic test_reset_mid();
    cur = "reset_mid";
    step(0, 1'b1, 64'hF0, 1'b0, -1);
    step(1, 1'b1, 64'h03, 1'b0, -1);
    #2;
    resetn = 1'b0;
    #1;
    check_reset_state();
    model_reset();
    drive(0, 1'b0, 64'd0, 1'b1);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    step(0, 1'b1, 64'hFF, 1'b1, 0);
    step(1, 1'b1, 64'h1F, 1'b1, 0);
  endtask

  initial begin
    resetn = 1'b0;
    drive(0, 1'b0, 64'd0, 1'b1);
    test_reset();
    test_rr_sweep();
    test_wrap5();
    test_stall();
    test_prio16();
    test_zero_req();
    test_multihot();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
